execution_stage: RTL and testbench

- EX stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Consumes the decode stage's registered A, B, RD and ALUctr, and produces a registered ALU result and destination register for the MEM/WB path.
- Adds an iterative shift-add multiplier (ALUctr 5) that holds the pipeline through a stall output while it runs.

---
 rtl/execution_stage.sv | 133 +++++++++++++
 tb/tb_execution_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/execution_stage.sv
// EX stage of the 5-stage MIPS pipeline. Single-cycle ALU ops (add, sub,
// and, or, slt) plus an optional 32-step shift-add multiplier. While the
// multiplier runs, stall is held high so upstream freezes its operands.
module execution_stage #(
   parameter bit MUL_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [4:0]  RD,
   input  logic [2:0]  ALUctr,
   output logic [31:0] EM_ALUout,
   output logic [4:0]  EM_RD,
   output logic        EM_zero,
   output logic        stall
);

   typedef enum logic {IDLE, MUL} state_t;

   state_t      state_q,  state_d;
   logic [31:0] mcand_q,  mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [31:0] acc_q,    acc_d;
   logic [4:0]  count_q,  count_d;
   logic [4:0]  rd_q,     rd_d;
   logic [31:0] alu_q,    alu_d;
   logic [4:0]  emrd_q,   emrd_d;
   logic        zero_q,   zero_d;
   logic [31:0] step;

   // Single-cycle ALU operations; only called for ALUctr 0-4.
   function automatic logic [31:0] alu_op(input logic [2:0] ctr,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      case (ctr)
         3'd0:    r = a + b;
         3'd1:    r = a - b;
         3'd2:    r = a & b;
         3'd3:    r = a | b;
         3'd4:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Next-state, multiplier datapath and output-register selection.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      rd_d     = rd_q;
      alu_d    = alu_q;
      emrd_d   = emrd_q;
      zero_d   = zero_q;
      step     = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
      case (state_q)
         IDLE: begin
            if (MUL_ENABLE && ALUctr == 3'd5) begin
               mcand_d  = A;
               mplier_d = B;
               rd_d     = RD;
               acc_d    = '0;
               count_d  = '0;
               alu_d    = '0;
               emrd_d   = '0;
               zero_d   = 1'b0;
               state_d  = MUL;
            end else if (ALUctr <= 3'd4) begin
               alu_d  = alu_op(ALUctr, A, B);
               emrd_d = RD;
               zero_d = (A == B);
            end else begin
               // Reserved op (or mul with the multiplier disabled): bubble.
               alu_d  = '0;
               emrd_d = '0;
               zero_d = 1'b0;
            end
         end
         MUL: begin
            acc_d    = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 5'd1;
            alu_d    = '0;
            emrd_d   = '0;
            zero_d   = 1'b0;
            // Last step: publish the sum including this step's partial product.
            if (count_q == 5'd31) begin
               alu_d   = step;
               emrd_d  = rd_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; async reset also aborts a multiply.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         rd_q     <= '0;
         alu_q    <= '0;
         emrd_q   <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
         rd_q     <= rd_d;
         alu_q    <= alu_d;
         emrd_q   <= emrd_d;
         zero_q   <= zero_d;
      end
   end

   assign stall     = (state_q == MUL);
   assign EM_ALUout = alu_q;
   assign EM_RD     = emrd_q;
   assign EM_zero   = zero_q;

endmodule

// File: tb/tb_execution_stage.sv
// Bench for execution_stage: a driver queues the expected post-edge outputs
// for each cycle it issues; a monitor pops one entry after every rising edge.
module tb_execution_stage;

   logic        clk;
   logic        rst;
   logic [31:0] A, B;
   logic [4:0]  RD;
   logic [2:0]  ALUctr;
   logic [31:0] EM_ALUout, EM_ALUout_nm;
   logic [4:0]  EM_RD, EM_RD_nm;
   logic        EM_zero, EM_zero_nm;
   logic        stall, stall_nm;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        z;
      logic        st;
      string       name;
   } exp_t;

   exp_t expq[$];

   execution_stage #(.MUL_ENABLE(1'b1)) dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .RD(RD), .ALUctr(ALUctr),
      .EM_ALUout(EM_ALUout), .EM_RD(EM_RD), .EM_zero(EM_zero), .stall(stall)
   );

   execution_stage #(.MUL_ENABLE(1'b0)) dut_nm (
      .clk(clk), .rst(rst), .A(A), .B(B), .RD(RD), .ALUctr(ALUctr),
      .EM_ALUout(EM_ALUout_nm), .EM_RD(EM_RD_nm), .EM_zero(EM_zero_nm), .stall(stall_nm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] alu, input logic [4:0] rd,
                        input logic z, input logic st,
                        input logic [31:0] ealu, input logic [4:0] erd,
                        input logic ez, input logic est);
      checks++;
      if (alu !== ealu || rd !== erd || z !== ez || st !== est) begin
         errors++;
         $display("FAIL %s: got alu=%h rd=%0d zero=%b stall=%b, want alu=%h rd=%0d zero=%b stall=%b",
                  name, alu, rd, z, st, ealu, erd, ez, est);
      end
   endtask

   // Monitor: compare DUT outputs against the scoreboard after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check(e.name, EM_ALUout, EM_RD, EM_zero, stall, e.alu, e.rd, e.z, e.st);
         end
      end
   end

   // Drive one instruction at the falling edge and queue what the next edge should show.
   task automatic cycle(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [2:0] ctr, input logic [31:0] ealu, input logic [4:0] erd,
                        input logic ez, input logic est, input string name);
      exp_t e;
      @(negedge clk);
      A = a; B = b; RD = rd; ALUctr = ctr;
      e.alu = ealu; e.rd = erd; e.z = ez; e.st = est; e.name = name;
      expq.push_back(e);
      @(posedge clk);
   endtask

   // Full multiply: accept edge, 31 busy edges, completion edge.
   // The following instruction (na/nb/nrd/nctr) is held on the inputs meanwhile.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] prod,
                         input logic [31:0] na, input logic [31:0] nb, input logic [4:0] nrd,
                         input logic [2:0] nctr, input string name);
      cycle(a, b, rd, 3'd5, 32'd0, 5'd0, 1'b0, 1'b1, {name, "_accept"});
      for (int i = 1; i < 32; i++)
         cycle(na, nb, nrd, nctr, 32'd0, 5'd0, 1'b0, 1'b1, {name, "_busy"});
      cycle(na, nb, nrd, nctr, prod, rd, 1'b0, 1'b0, {name, "_result"});
   endtask

   initial begin
      int stall_nm_bad;
      A = '0; B = '0; RD = '0; ALUctr = '0;
      rst = 1'b0;
      #12;
      check("reset_state", EM_ALUout, EM_RD, EM_zero, stall, 32'd0, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Single-cycle ALU ops.
      cycle(32'd5, 32'd7, 5'd3, 3'd0, 32'd12, 5'd3, 1'b0, 1'b0, "add");
      cycle(32'd3, 32'd5, 5'd2, 3'd1, 32'hFFFF_FFFE, 5'd2, 1'b0, 1'b0, "sub_neg");
      cycle(32'hFFFF_FFFF, 32'd1, 5'd5, 3'd4, 32'd1, 5'd5, 1'b0, 1'b0, "slt_true");
      cycle(32'd1, 32'hFFFF_FFFF, 5'd6, 3'd4, 32'd0, 5'd6, 1'b0, 1'b0, "slt_false");
      cycle(32'h1234, 32'h1234, 5'd7, 3'd1, 32'd0, 5'd7, 1'b1, 1'b0, "sub_zero");
      cycle(32'hF0F0_1234, 32'h0FF0_FF00, 5'd8, 3'd2, 32'h00F0_1200, 5'd8, 1'b0, 1'b0, "and");
      cycle(32'hF000_0001, 32'h0000_0F10, 5'd9, 3'd3, 32'hF000_0F11, 5'd9, 1'b0, 1'b0, "or");
      cycle(32'hFFFF_FFFF, 32'd1, 5'd0, 3'd0, 32'd0, 5'd0, 1'b0, 1'b0, "add_wrap_rd0");
      cycle(32'd9, 32'd9, 5'd10, 3'd6, 32'd0, 5'd0, 1'b0, 1'b0, "reserved6");
      cycle(32'd9, 32'd9, 5'd11, 3'd7, 32'd0, 5'd0, 1'b0, 1'b0, "reserved7");

      // Multiply with held follow-on add; the disabled instance treats mul as a bubble.
      cycle(32'h0001_0003, 32'd5, 5'd9, 3'd5, 32'd0, 5'd0, 1'b0, 1'b1, "mul1_accept");
      #1;
      check("nomul_bubble", EM_ALUout_nm, EM_RD_nm, EM_zero_nm, stall_nm, 32'd0, 5'd0, 1'b0, 1'b0);
      stall_nm_bad = 0;
      for (int i = 1; i < 32; i++) begin
         cycle(32'd1, 32'd1, 5'd4, 3'd0, 32'd0, 5'd0, 1'b0, 1'b1, "mul1_busy");
         if (stall_nm !== 1'b0) stall_nm_bad++;
      end
      checks++;
      if (stall_nm_bad != 0) begin
         errors++;
         $display("FAIL nomul_stall: got %0d cycles with stall high, want 0", stall_nm_bad);
      end
      cycle(32'd1, 32'd1, 5'd4, 3'd0, 32'h0005_000F, 5'd9, 1'b0, 1'b0, "mul1_result");
      cycle(32'd1, 32'd1, 5'd4, 3'd0, 32'd2, 5'd4, 1'b1, 1'b0, "held_add");
      #1;
      check("nomul_add", EM_ALUout_nm, EM_RD_nm, EM_zero_nm, stall_nm, 32'd2, 5'd4, 1'b1, 1'b0);

      // Back-to-back multiplies: overflow product, then a zero multiplier.
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd1,
             32'h1234, 32'd0, 5'd8, 3'd5, "mul_ovf");
      do_mul(32'h1234, 32'd0, 5'd8, 32'd0,
             32'd6, 32'd2, 5'd12, 3'd1, "mul_zero");
      cycle(32'd6, 32'd2, 5'd12, 3'd1, 32'd4, 5'd12, 1'b0, 1'b0, "sub_after_mul");

      // Reset during a multiply: outputs clear immediately, no partial result.
      cycle(32'd7, 32'd3, 5'd13, 3'd5, 32'd0, 5'd0, 1'b0, 1'b1, "mulrst_accept");
      for (int i = 1; i < 10; i++)
         cycle(32'd7, 32'd3, 5'd13, 3'd5, 32'd0, 5'd0, 1'b0, 1'b1, "mulrst_busy");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_mul_reset", EM_ALUout, EM_RD, EM_zero, stall, 32'd0, 5'd0, 1'b0, 1'b0);
      A = 32'd2; B = 32'd2; RD = 5'd1; ALUctr = 3'd0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      cycle(32'd2, 32'd2, 5'd1, 3'd0, 32'd4, 5'd1, 1'b1, 1'b0, "add_after_reset");

      // Drain the scoreboard within a bounded number of edges.
      for (int i = 0; i < 4 && expq.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no completion by 100000, want completion");
      $fatal(1, "timeout");
   end

endmodule
